// File: rtl/mfcc_framer_if.sv
// PCM input stream and zero-padded frame output stream of the MFCC framer.
interface mfcc_framer_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int CH_W         = 1,
    parameter int IDX_W        = 9
);
    logic [SAMPLE_WIDTH-1:0] pcm_in;
    logic [CH_W-1:0]         pcm_ch_i;
    logic                    pcm_valid_i;
    logic                    pcm_ready_o;
    logic                    drop_o;
    logic [SAMPLE_WIDTH-1:0] frame_data_o;
    logic [CH_W-1:0]         frame_ch_o;
    logic [IDX_W-1:0]        frame_idx_o;
    logic                    frame_last_o;
    logic                    frame_valid_o;
    logic                    frame_ready_i;

    modport slave (
        input  pcm_in, pcm_ch_i, pcm_valid_i, frame_ready_i,
        output pcm_ready_o, drop_o, frame_data_o, frame_ch_o, frame_idx_o,
               frame_last_o, frame_valid_o
    );
    modport master (
        output pcm_in, pcm_ch_i, pcm_valid_i, frame_ready_i,
        input  pcm_ready_o, drop_o, frame_data_o, frame_ch_o, frame_idx_o,
               frame_last_o, frame_valid_o
    );
endinterface

// File: rtl/mfcc_framer.sv
// Multi-channel MFCC front end: per-channel pre-emphasis into a frame ring,
// round-robin selection of full rings and zero-padded frame streaming.
module mfcc_framer_ch #(
    parameter int SW    = 16,
    parameter int FS    = 306,
    parameter int FM    = 123,
    parameter int ALPHA = 31785,
    parameter int CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr,
    input  logic signed [SW-1:0] i_x,
    input  logic [CNT_W-1:0]     i_off,
    input  logic                 i_pop,
    output logic [SW-1:0]        o_rd,
    output logic                 o_full
);
    localparam logic [CNT_W-1:0]   FS_C    = CNT_W'(FS);
    localparam logic [CNT_W-1:0]   FS_M1   = CNT_W'(FS - 1);
    localparam logic [CNT_W-1:0]   FM_C    = CNT_W'(FM);
    localparam logic [CNT_W-1:0]   ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]     FS_W    = (CNT_W+1)'(FS);
    localparam logic [CNT_W:0]     FM_W    = (CNT_W+1)'(FM);
    localparam logic signed [31:0] ALPHA_S = 32'(ALPHA);
    localparam logic signed [32:0] SMAX    = 33'((64'sd1 <<< (SW-1)) - 64'sd1);
    localparam logic signed [32:0] SMIN    = -SMAX - 33'sd1;

    logic [SW-1:0]        r_ring [FS];
    logic [CNT_W-1:0]     r_cnt, r_wr_ptr, r_base;
    logic signed [SW-1:0] r_xprev;
    logic signed [31:0]   w_prod, w_sh;
    logic signed [32:0]   w_diff;
    logic [SW-1:0]        w_y;
    logic [CNT_W:0]       w_rsum, w_bsum;
    logic [CNT_W-1:0]     w_raddr, w_bnext, w_wnext;

    // y = sat(x - ((ALPHA*x_prev) >>> 15)), 32-bit signed product
    assign w_prod = ALPHA_S * 32'(r_xprev);
    assign w_sh   = w_prod >>> 15;
    assign w_diff = 33'(i_x) - 33'(w_sh);

    always_comb begin
        if (w_diff > SMAX)      w_y = SMAX[SW-1:0];
        else if (w_diff < SMIN) w_y = SMIN[SW-1:0];
        else                    w_y = w_diff[SW-1:0];
    end

    assign w_rsum  = {1'b0, r_base} + {1'b0, i_off};
    assign w_raddr = (w_rsum >= FS_W) ? CNT_W'(w_rsum - FS_W) : CNT_W'(w_rsum);
    assign w_bsum  = {1'b0, r_base} + FM_W;
    assign w_bnext = (w_bsum >= FS_W) ? CNT_W'(w_bsum - FS_W) : CNT_W'(w_bsum);
    assign w_wnext = (r_wr_ptr == FS_M1) ? '0 : r_wr_ptr + ONE;
    assign o_rd    = r_ring[w_raddr];
    assign o_full  = (r_cnt == FS_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_base   <= '0;
            r_xprev  <= '0;
        end else begin
            // a ring is full while it streams, so pop and write never coincide
            if (i_pop) begin
                r_cnt  <= r_cnt - FM_C;
                r_base <= w_bnext;
            end else if (i_wr) begin
                r_cnt <= r_cnt + ONE;
            end
            if (i_wr) begin
                r_wr_ptr <= w_wnext;
                r_xprev  <= i_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr) r_ring[r_wr_ptr] <= w_y;
    end
endmodule

module mfcc_framer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int FRAME_SIZE   = 306,
    parameter int FRAME_MOVE   = 123,
    parameter int FFT_SIZE     = 512,
    parameter int ALPHA        = 31785
) (
    input  logic          clk,
    input  logic          rst_n,
    mfcc_framer_if.slave  bus
);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam int CNT_W = $clog2(FRAME_SIZE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_SIZE - 1);
    localparam logic [IDX_W:0]   FS_I     = (IDX_W+1)'(FRAME_SIZE);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CH_W:0]    NCH      = (CH_W+1)'(NUM_CHANNELS);

    if (FRAME_MOVE < 1 || FRAME_MOVE > FRAME_SIZE || FRAME_SIZE > FFT_SIZE ||
        (FFT_SIZE & (FFT_SIZE - 1)) != 0 || NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_param_chk
        $error("mfcc_framer: illegal parameter combination");
    end

    typedef enum logic {S_IDLE, S_STREAM} state_t;
    state_t r_state, w_state_nxt;

    logic [CH_W-1:0]                            r_rr, r_ch, w_sel, w_rr_inc, w_ch_inc;
    logic [IDX_W-1:0]                           r_idx;
    logic [SAMPLE_WIDTH-1:0]                    r_data, w_rd;
    logic                                       r_valid, r_drop;
    logic [NUM_CHANNELS-1:0]                    w_full, w_wr, w_pop;
    logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0]  w_rd_data;
    logic [IDX_W:0]                             w_idx_inc;
    logic [CNT_W-1:0]                           w_off;
    logic                                       w_ready, w_accept, w_start, w_adv, w_end;

    assign w_ready  = ({1'b0, bus.pcm_ch_i} < NCH) && !w_full[bus.pcm_ch_i];
    assign w_accept = bus.pcm_valid_i && w_ready;

    genvar g;
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign w_wr[g]  = w_accept && (bus.pcm_ch_i == CH_W'(g));
        assign w_pop[g] = w_end && (r_ch == CH_W'(g));
        mfcc_framer_ch #(
            .SW(SAMPLE_WIDTH), .FS(FRAME_SIZE), .FM(FRAME_MOVE), .ALPHA(ALPHA), .CNT_W(CNT_W)
        ) u_ch (
            .clk(clk), .rst_n(rst_n), .i_wr(w_wr[g]), .i_x($signed(bus.pcm_in)),
            .i_off(w_off), .i_pop(w_pop[g]), .o_rd(w_rd_data[g]), .o_full(w_full[g])
        );
    end

    // IDLE reads the candidate's rd_base; STREAM prefetches the next beat
    assign w_sel     = (r_state == S_IDLE) ? r_rr : r_ch;
    assign w_rd      = w_rd_data[w_sel];
    assign w_idx_inc = {1'b0, r_idx} + (IDX_W+1)'(1);
    assign w_off     = (r_state == S_STREAM && w_idx_inc < FS_I) ? CNT_W'(w_idx_inc) : '0;
    assign w_rr_inc  = (r_rr == CH_LAST) ? '0 : r_rr + CH_W'(1);
    assign w_ch_inc  = (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_full[r_rr]) w_state_nxt = S_STREAM;
            S_STREAM: if (bus.frame_ready_i && r_idx == IDX_LAST) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_end   = 1'b0;
        case (r_state)
            S_IDLE:   w_start = w_full[r_rr];
            S_STREAM: begin
                w_adv = bus.frame_ready_i && (r_idx != IDX_LAST);
                w_end = bus.frame_ready_i && (r_idx == IDX_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= '0;
            r_ch    <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= bus.pcm_valid_i && !w_ready;
            if (w_start) begin
                r_ch    <= r_rr;
                r_idx   <= '0;
                r_data  <= w_rd;
                r_valid <= 1'b1;
            end else if (w_adv) begin
                r_idx  <= w_idx_inc[IDX_W-1:0];
                r_data <= (w_idx_inc < FS_I) ? w_rd : '0;
            end else if (w_end) begin
                r_idx   <= '0;
                r_data  <= '0;
                r_valid <= 1'b0;
                r_rr    <= w_ch_inc;
            end
            if (r_state == S_IDLE && !w_full[r_rr]) r_rr <= w_rr_inc;
        end
    end

    assign bus.pcm_ready_o   = w_ready;
    assign bus.drop_o        = r_drop;
    assign bus.frame_data_o  = r_data;
    assign bus.frame_ch_o    = r_ch;
    assign bus.frame_idx_o   = r_idx;
    assign bus.frame_valid_o = r_valid;
    assign bus.frame_last_o  = r_valid && (r_idx == IDX_LAST);
endmodule

// File: tb/tb_mfcc_framer.sv
// Randomized bench for mfcc_framer: a queue-per-channel reference model predicts
// every emitted beat, ready level, drop pulse and the frame channel order.
module tb_mfcc_framer;
    localparam int SW = 16, NCH = 2, FS = 306, FM = 123, FFT = 512, ALPHA = 31785;
    localparam int CH_W = 1, IDX_W = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mfcc_framer_if #(.SAMPLE_WIDTH(SW), .CH_W(CH_W), .IDX_W(IDX_W)) bus();

    mfcc_framer #(
        .SAMPLE_WIDTH(SW), .NUM_CHANNELS(NCH), .FRAME_SIZE(FS), .FRAME_MOVE(FM),
        .FFT_SIZE(FFT), .ALPHA(ALPHA)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // reference: pre-emphasis straight from the arithmetic definition
    function automatic int pre(input int x, input int xp);
        longint p, d;
        p = (longint'(ALPHA) * longint'(xp)) >>> 15;
        d = longint'(x) - p;
        if (d > 32767)  return 32767;
        if (d < -32768) return -32768;
        return int'(d);
    endfunction

    int q[NCH][$];
    int xprev[NCH];
    int frm_ch_log[$];
    int last_frm[FFT];
    int drops = 0, frames_done = 0, fv_seen = 0, beat = 0, cur_ch = 0;
    int mc, mx, m_exp;
    bit m_rdy, exp_drop = 0, prev_stall = 0;
    logic [SW-1:0]    prev_data;
    logic [IDX_W-1:0] prev_idx;
    logic [CH_W-1:0]  prev_ch;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                q[c].delete();
                xprev[c] = 0;
            end
            exp_drop   = 0;
            prev_stall = 0;
            beat       = 0;
        end else begin
            chk("drop", bus.drop_o, exp_drop);
            drops += int'(bus.drop_o);
            exp_drop = 0;
            if (bus.pcm_valid_i) begin
                mc    = int'(bus.pcm_ch_i);
                m_rdy = (q[mc].size() < FS);
                chk("pcm_ready", bus.pcm_ready_o, m_rdy);
                if (m_rdy) begin
                    mx = int'($signed(bus.pcm_in));
                    q[mc].push_back(pre(mx, xprev[mc]));
                    xprev[mc] = mx;
                end else begin
                    exp_drop = 1;
                end
            end
            if (prev_stall) begin
                chk("hold_valid", bus.frame_valid_o, 1);
                chk("hold_data", bus.frame_data_o, prev_data);
                chk("hold_idx", bus.frame_idx_o, prev_idx);
                chk("hold_ch", bus.frame_ch_o, prev_ch);
            end
            prev_stall = bus.frame_valid_o && !bus.frame_ready_i;
            prev_data  = bus.frame_data_o;
            prev_idx   = bus.frame_idx_o;
            prev_ch    = bus.frame_ch_o;
            if (bus.frame_valid_o) fv_seen++;
            if (bus.frame_valid_o && bus.frame_ready_i) begin
                if (beat == 0) begin
                    cur_ch = int'(bus.frame_ch_o);
                    chk("frame_full", q[cur_ch].size() >= FS, 1);
                end
                chk("frame_ch", bus.frame_ch_o, cur_ch);
                chk("frame_idx", bus.frame_idx_o, beat);
                chk("frame_last", bus.frame_last_o, beat == FFT - 1);
                m_exp = (beat < FS && q[cur_ch].size() > beat) ? q[cur_ch][beat] : 0;
                chk("frame_data", $signed(bus.frame_data_o), m_exp);
                last_frm[beat] = int'($signed(bus.frame_data_o));
                if (beat == FFT - 1) begin
                    repeat (FM) if (q[cur_ch].size() > 0) void'(q[cur_ch].pop_front());
                    frm_ch_log.push_back(cur_ch);
                    frames_done++;
                    beat = 0;
                end else begin
                    beat++;
                end
            end
        end
    end

    int rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: stalled
    initial begin
        bus.frame_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.frame_ready_i = 1'b1;
                1:       bus.frame_ready_i = 1'($urandom % 2);
                default: bus.frame_ready_i = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int x);
        int n = 0;
        bus.pcm_ch_i    = CH_W'(ch);
        bus.pcm_in      = 16'(x);
        bus.pcm_valid_i = 1'b0;
        #1;
        while (!bus.pcm_ready_o && n < 4000) begin
            tick();
            #1;
            n++;
        end
        if (n >= 4000) chk("push_timeout", n, 0);
        bus.pcm_valid_i = 1'b1;
        tick();
        bus.pcm_valid_i = 1'b0;
    endtask

    task automatic push_raw(input int ch, input int x);
        bus.pcm_ch_i    = CH_W'(ch);
        bus.pcm_in      = 16'(x);
        bus.pcm_valid_i = 1'b1;
        tick();
        bus.pcm_valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 5000) begin
            tick();
            k++;
        end
        chk("frames_done", frames_done, n);
    endtask

    function automatic int rnd();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    int d0, f0, fv0, found;

    initial begin
        bus.pcm_in = '0;
        bus.pcm_ch_i = '0;
        bus.pcm_valid_i = 1'b0;
        #12;
        chk("rst_valid", bus.frame_valid_o, 0);
        chk("rst_data", bus.frame_data_o, 0);
        chk("rst_idx", bus.frame_idx_o, 0);
        chk("rst_ch", bus.frame_ch_o, 0);
        chk("rst_drop", bus.drop_o, 0);
        chk("rst_last", bus.frame_last_o, 0);
        chk("rst_ready", bus.pcm_ready_o, 1);
        tick();
        rst_n = 1'b1;

        // ramp into channel 0, one full frame
        for (int i = 1; i <= FS; i++) push(0, i);
        bus.pcm_ch_i = '0;
        #1;
        chk("t1_ready_full", bus.pcm_ready_o, 0);
        wait_frames(1);
        chk("t1_ready_after", bus.pcm_ready_o, 1);
        chk("t1_beat0", last_frm[0], 1);
        chk("t1_beat305", last_frm[305], pre(306, 305));
        chk("t1_pad", last_frm[FFT-1], 0);

        // hop: second frame starts at sample 124
        for (int i = FS + 1; i <= FS + FM; i++) push(0, i);
        wait_frames(2);
        chk("t2_beat0", last_frm[0], pre(124, 123));
        chk("t2_beat182", last_frm[182], pre(306, 305));
        chk("t2_beat305", last_frm[305], pre(429, 428));

        // constant input and saturation on channel 1
        for (int i = 0; i < 300; i++) push(1, 1000);
        push(1, 32767);
        push(1, -32768);
        push(1, 32767);
        for (int i = 0; i < 3; i++) push(1, 1000);
        wait_frames(3);
        chk("t3_ch", frm_ch_log[2], 1);
        chk("t3_b0", last_frm[0], 1000);
        chk("t3_b1", last_frm[1], 30);
        chk("t3_b299", last_frm[299], 30);
        chk("t3_b300", last_frm[300], 31797);
        chk("t3_sat_neg", last_frm[301], -32768);
        chk("t3_sat_pos", last_frm[302], 32767);
        chk("t3_b303", last_frm[303], -30784);

        // random backpressure
        rdy_mode = 1;
        for (int i = 0; i < FM; i++) push(0, rnd());
        wait_frames(4);

        // drops while the full ring is stalled
        rdy_mode = 2;
        for (int i = 0; i < FM; i++) push(0, rnd());
        repeat (3) tick();
        d0 = drops;
        for (int i = 0; i < 5; i++) push_raw(0, rnd());
        repeat (2) tick();
        chk("t5_drops", drops - d0, 5);
        rdy_mode = 0;
        wait_frames(5);

        // both rings full: channel 0 first, then channel 1
        rdy_mode = 2;
        for (int i = 0; i < FM; i++) begin
            push(0, rnd());
            push(1, rnd());
        end
        rdy_mode = 0;
        wait_frames(7);
        chk("t6_order0", frm_ch_log[5], 0);
        chk("t6_order1", frm_ch_log[6], 1);

        // reset in the middle of a frame
        for (int i = 0; i < FM; i++) push(0, rnd());
        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            if (bus.frame_valid_o && bus.frame_idx_o == 9'd200) found = 1;
            else tick();
        end
        chk("t6_reach200", found, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.frame_valid_o, 0);
        chk("t6_rst_data", bus.frame_data_o, 0);
        chk("t6_rst_idx", bus.frame_idx_o, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        f0  = frames_done;
        fv0 = fv_seen;
        for (int i = 0; i < FS - 1; i++) push(0, rnd());
        repeat (50) tick();
        chk("t6_no_frame", fv_seen - fv0, 0);
        push(0, rnd());
        wait_frames(f0 + 1);
        chk("t6_post_ch", frm_ch_log[f0], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
